// File: rtl/mmu_arbiter.sv
// Round-robin arbiter with burst lock and read-return routing for the shared MMU port.
// Optional macro MMU_ARB_LOCK_LIMIT_EN bounds a lock to LOCK_MAX consecutive grants.
module mmu_arbiter #(
  parameter int NREQ     = 3,
  parameter int AW       = 16,
  parameter int DW       = 16,
  parameter int RD_LAT   = 1,
  parameter int LOCK_MAX = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_i,
  input  logic [NREQ-1:0]    lock_i,
  input  logic [NREQ-1:0]    we_i,
  input  logic [NREQ*AW-1:0] addr_i,
  input  logic [NREQ*DW-1:0] wdata_i,
  output logic [NREQ-1:0]    gnt_o,
  output logic [NREQ-1:0]    rvalid_o,
  output logic [DW-1:0]      rdata_o,
  output logic [AW-1:0]      mmu_address_o,
  output logic               mmu_we_o,
  output logic [DW-1:0]      mmu_data_o,
  input  logic [DW-1:0]      mmu_data_i,
  output logic [1:0]         owner_o,
  output logic               locked_o
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_OPEN   = 2'd1;
  localparam logic [1:0] S_LOCKED = 2'd2;

  if (NREQ < 1 || NREQ > 4 || RD_LAT < 1 || RD_LAT > 4 || LOCK_MAX < 1) begin : g_bad_param
    $error("mmu_arbiter: unsupported parameter value");
  end

  logic [1:0]    state_q, state_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [1:0]    owner_q, owner_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          win_vld;
  logic [1:0]    win;
  logic [1:0]    idx;
  logic          lock_hit;
  logic          break_lock;

  logic          vld_q [RD_LAT];
  logic [1:0]    id_q  [RD_LAT];

`ifdef MMU_ARB_LOCK_LIMIT_EN
  localparam int CW = $clog2(LOCK_MAX + 1);
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] owner_mask;

  assign owner_mask = NREQ'(1) << owner_q;
  assign break_lock = (state_q == S_LOCKED) && (cnt_q >= CW'(LOCK_MAX)) && |(req_i & ~owner_mask);
`else
  assign break_lock = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    addr_d   = addr_q;
    win_vld  = 1'b0;
    win      = owner_q;
    idx      = '0;
    lock_hit = 1'b0;
    if (state_q == S_LOCKED && req_i[owner_q] && lock_i[owner_q] && !break_lock) begin
      win_vld  = 1'b1;
      lock_hit = 1'b1;
    end else begin
      // Circular scan starting just after the last winner; a released lock resumes from its owner.
      for (int k = 1; k <= NREQ; k++) begin
        idx = 2'((int'(ptr_q) + k) % NREQ);
        if (!win_vld && req_i[idx]) begin
          win_vld = 1'b1;
          win     = idx;
        end
      end
    end
    if (win_vld) begin
      ptr_d   = win;
      owner_d = win;
      addr_d  = addr_i[int'(win)*AW +: AW];
      state_d = lock_i[win] ? S_LOCKED : S_OPEN;
    end else begin
      state_d = S_IDLE;
    end
  end

`ifdef MMU_ARB_LOCK_LIMIT_EN
  always_comb begin
    cnt_d = '0;
    if (lock_hit)
      cnt_d = (cnt_q >= CW'(LOCK_MAX)) ? cnt_q : cnt_q + CW'(1);
    else if (win_vld && lock_i[win])
      cnt_d = CW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ptr_q   <= 2'(NREQ - 1);
      owner_q <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
    end
  end

  // Read tag pipeline: head captures the issue, tail lines up with MMU data_out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < RD_LAT; i++) vld_q[i] <= 1'b0;
    end else begin
      vld_q[0] <= win_vld && !we_i[win];
      for (int i = 1; i < RD_LAT; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    id_q[0] <= win;
    for (int i = 1; i < RD_LAT; i++) id_q[i] <= id_q[i-1];
  end

  assign gnt_o         = (rst && win_vld) ? (NREQ'(1) << win) : '0;
  assign mmu_address_o = rst ? addr_d : '0;
  assign mmu_we_o      = rst && win_vld && we_i[win];
  assign mmu_data_o    = (rst && win_vld) ? wdata_i[int'(win)*DW +: DW] : '0;
  assign rvalid_o      = vld_q[RD_LAT-1] ? (NREQ'(1) << id_q[RD_LAT-1]) : '0;
  assign rdata_o       = vld_q[RD_LAT-1] ? mmu_data_i : '0;
  assign owner_o       = owner_q;
  assign locked_o      = (state_q == S_LOCKED);

endmodule

// File: tb/tb_mmu_arbiter.sv
// Scoreboard bench for mmu_arbiter: a behavioural MMU memory, read returns checked in order.
module tb_mmu_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  req = '0, lock = '0, we = '0;
  logic [15:0] a0 = '0, a1 = '0, a2 = '0, d0 = '0, d1 = '0, d2 = '0;
  logic [2:0]  gnt_o, rvalid_o;
  logic [15:0] rdata_o, mmu_address_o, mmu_data_o;
  logic        mmu_we_o, locked_o;
  logic [1:0]  owner_o;
  logic [15:0] mmu_dout = '0;
  logic [15:0] mem [0:65535];

  typedef struct packed {
    logic [2:0]  id;
    logic [15:0] data;
  } ret_t;
  ret_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mmu_arbiter dut (
    .clk(clk), .rst(rst), .req_i(req), .lock_i(lock), .we_i(we),
    .addr_i({a2, a1, a0}), .wdata_i({d2, d1, d0}),
    .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .mmu_address_o(mmu_address_o), .mmu_we_o(mmu_we_o), .mmu_data_o(mmu_data_o),
    .mmu_data_i(mmu_dout), .owner_o(owner_o), .locked_o(locked_o)
  );

  always @(posedge clk) begin
    if (mmu_we_o) mem[mmu_address_o] <= mmu_data_o;
    mmu_dout <= mem[mmu_address_o];
  end

  // Return monitor: every rvalid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rvalid_o !== 3'b000) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_rvalid got rvalid=%b rdata=%h, required no return", rvalid_o, rdata_o);
      end else begin
        ret_t e;
        e = sb.pop_front();
        if (rvalid_o !== e.id || rdata_o !== e.data) begin
          n_fail++;
          $display("FAIL read_return got rvalid=%b rdata=%h, required rvalid=%b rdata=%h", rvalid_o, rdata_o, e.id, e.data);
        end
      end
    end
  end

  task automatic drain(input int n, input string name);
    repeat (n) @(negedge clk);
    #1;
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL %s_drain got %0d outstanding, required 0", name, sb.size()); sb.delete(); end
  endtask

  task automatic test_reset;
    req = 3'b111; we = 3'b111; a0 = 16'h0055; a1 = 16'h0066; a2 = 16'h0077; d0 = 16'hAAAA;
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (gnt_o !== 3'b000) begin n_fail++; $display("FAIL rst_gnt got %b, required 000", gnt_o); end
    n_checks++; if (mmu_we_o !== 1'b0) begin n_fail++; $display("FAIL rst_we got %b, required 0", mmu_we_o); end
    n_checks++; if (mmu_address_o !== 16'h0) begin n_fail++; $display("FAIL rst_addr got %h, required 0000", mmu_address_o); end
    n_checks++; if (mmu_data_o !== 16'h0) begin n_fail++; $display("FAIL rst_data got %h, required 0000", mmu_data_o); end
    n_checks++; if (rvalid_o !== 3'b000 || rdata_o !== 16'h0) begin n_fail++; $display("FAIL rst_ret got %b/%h, required 000/0000", rvalid_o, rdata_o); end
    n_checks++; if (owner_o !== 2'd0 || locked_o !== 1'b0) begin n_fail++; $display("FAIL rst_owner got %0d/%b, required 0/0", owner_o, locked_o); end
    @(negedge clk);
    req = '0; we = '0; rst = 1'b1;
  endtask

  task automatic test_read;
    @(negedge clk);
    req = 3'b001; we = 3'b000; a0 = 16'h0010;
    #1;
    n_checks++; if (gnt_o !== 3'b001) begin n_fail++; $display("FAIL read_gnt got %b, required 001", gnt_o); end
    n_checks++; if (mmu_address_o !== 16'h0010 || mmu_we_o !== 1'b0) begin n_fail++; $display("FAIL read_bus got %h/%b, required 0010/0", mmu_address_o, mmu_we_o); end
    sb.push_back('{id: 3'b001, data: 16'h1234});
    @(negedge clk);
    req = '0;
    #1;
    n_checks++; if (mmu_address_o !== 16'h0010 || gnt_o !== 3'b000) begin n_fail++; $display("FAIL idle_hold got %h/%b, required 0010/000", mmu_address_o, gnt_o); end
    drain(2, "read");
  endtask

  task automatic test_write;
    @(negedge clk);
    req = 3'b100; we = 3'b100; a2 = 16'h0100; d2 = 16'hBEEF;
    #1;
    n_checks++; if (gnt_o !== 3'b100) begin n_fail++; $display("FAIL write_gnt got %b, required 100", gnt_o); end
    n_checks++; if (mmu_we_o !== 1'b1 || mmu_data_o !== 16'hBEEF || mmu_address_o !== 16'h0100) begin n_fail++; $display("FAIL write_bus got %b/%h/%h, required 1/beef/0100", mmu_we_o, mmu_data_o, mmu_address_o); end
    @(negedge clk);
    we = 3'b000;
    #1;
    n_checks++; if (gnt_o !== 3'b100 || mmu_we_o !== 1'b0) begin n_fail++; $display("FAIL readback_gnt got %b/%b, required 100/0", gnt_o, mmu_we_o); end
    sb.push_back('{id: 3'b100, data: 16'hBEEF});
    @(negedge clk);
    req = '0;
    drain(2, "write");
  endtask

  task automatic test_round_robin;
    logic [15:0] exp_data [3];
    exp_data[0] = 16'hA000; exp_data[1] = 16'hA001; exp_data[2] = 16'hA002;
    a0 = 16'h0020; a1 = 16'h0021; a2 = 16'h0022; we = 3'b000;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      req = 3'b111;
      #1;
      n_checks++; if (gnt_o !== 3'(1 << (i % 3))) begin n_fail++; $display("FAIL rr_gnt%0d got %b, required %b", i, gnt_o, 3'(1 << (i % 3))); end
      sb.push_back('{id: 3'(1 << (i % 3)), data: exp_data[i % 3]});
    end
    @(negedge clk);
    req = '0;
    #1;
    n_checks++; if (owner_o !== 2'd2) begin n_fail++; $display("FAIL rr_owner got %0d, required 2", owner_o); end
    drain(2, "rr");
  endtask

  task automatic test_lock;
    a0 = 16'h0300; a1 = 16'h0301; a2 = 16'h0302; we = 3'b111;
    @(negedge clk);
    req = 3'b001;
    #1;
    n_checks++; if (gnt_o !== 3'b001) begin n_fail++; $display("FAIL lock_setup got %b, required 001", gnt_o); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      req = 3'b111; lock = 3'b010;
      #1;
      n_checks++; if (gnt_o !== 3'b010) begin n_fail++; $display("FAIL lock_gnt%0d got %b, required 010", i, gnt_o); end
      if (i > 0) begin
        n_checks++; if (locked_o !== 1'b1) begin n_fail++; $display("FAIL lock_flag%0d got %b, required 1", i, locked_o); end
      end
    end
    @(negedge clk);
    req = 3'b101; lock = 3'b000;
    #1;
    n_checks++; if (gnt_o !== 3'b100) begin n_fail++; $display("FAIL unlock_gnt2 got %b, required 100", gnt_o); end
    @(negedge clk);
    #1;
    n_checks++; if (gnt_o !== 3'b001 || locked_o !== 1'b0) begin n_fail++; $display("FAIL unlock_gnt0 got %b/%b, required 001/0", gnt_o, locked_o); end
    @(negedge clk);
    req = '0; we = '0;
    drain(2, "lock");
  endtask

  task automatic test_reset_mid;
    a0 = 16'h0010; a1 = 16'h0021; a2 = 16'h0022; we = 3'b000;
    @(negedge clk);
    req = 3'b001;
    #1;
    n_checks++; if (gnt_o !== 3'b001) begin n_fail++; $display("FAIL mid_issue got %b, required 001", gnt_o); end
    @(posedge clk);
    #2;
    rst = 1'b0; req = '0;
    @(negedge clk);
    #1;
    n_checks++; if (rvalid_o !== 3'b000) begin n_fail++; $display("FAIL mid_discard got %b, required 000", rvalid_o); end
    @(negedge clk);
    rst = 1'b1; req = 3'b111;
    #1;
    n_checks++; if (gnt_o !== 3'b001 || rvalid_o !== 3'b000) begin n_fail++; $display("FAIL mid_restart got %b/%b, required 001/000", gnt_o, rvalid_o); end
    sb.push_back('{id: 3'b001, data: 16'h1234});
    @(negedge clk);
    req = '0;
    drain(2, "mid");
  endtask

  task automatic test_lock_limit;
    a0 = 16'h0400; a1 = 16'h0401; a2 = 16'h0402; we = 3'b111;
    @(negedge clk);
    req = 3'b100;
    #1;
    n_checks++; if (gnt_o !== 3'b100) begin n_fail++; $display("FAIL limit_setup got %b, required 100", gnt_o); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      req = 3'b011; lock = 3'b001;
      #1;
      n_checks++; if (gnt_o !== 3'b001) begin n_fail++; $display("FAIL limit_gnt%0d got %b, required 001", i, gnt_o); end
    end
    @(negedge clk);
    #1;
`ifdef MMU_ARB_LOCK_LIMIT_EN
    n_checks++; if (gnt_o !== 3'b010) begin n_fail++; $display("FAIL limit_break got %b, required 010", gnt_o); end
    @(negedge clk);
    req = '0; lock = '0;
    #1;
    n_checks++; if (locked_o !== 1'b0 || owner_o !== 2'd1) begin n_fail++; $display("FAIL limit_owner got %b/%0d, required 0/1", locked_o, owner_o); end
`else
    n_checks++; if (gnt_o !== 3'b001) begin n_fail++; $display("FAIL limit_hold got %b, required 001", gnt_o); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      n_checks++; if (gnt_o !== 3'b001 || locked_o !== 1'b1) begin n_fail++; $display("FAIL limit_hold%0d got %b/%b, required 001/1", i, gnt_o, locked_o); end
    end
    @(negedge clk);
    req = '0; lock = '0;
`endif
    we = '0;
    drain(2, "limit");
  endtask

  initial begin
    mem[16'h0010] = 16'h1234;
    mem[16'h0020] = 16'hA000;
    mem[16'h0021] = 16'hA001;
    mem[16'h0022] = 16'hA002;
    test_reset();
    test_read();
    test_write();
    test_round_robin();
    test_lock();
    test_reset_mid();
    test_lock_limit();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
